// File: rtl/acc_core.sv
// acc_core: AGC-flavoured accumulator CPU that runs one instruction per step pulse.
// Instructions and operands come over a generic synchronous read/write memory bus.
module acc_core #(
  parameter int            AW        = 12,
  parameter int            WW        = 15,
  parameter logic [AW-1:0] BOOT_ADDR = 12'h800,
  parameter logic [WW-1:0] G_INIT    = 15'h2A00
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [WW:0]   mem_wdata,
  input  logic [WW:0]   mem_rdata,
  output logic [WW-1:0] g_out,
  output logic [WW-1:0] a_out,
  output logic [AW-1:0] s_out,
  output logic          busy,
  output logic          inst_done
);

  typedef enum logic [2:0] {
    WAIT,
    FETCH,
    DECODE,
    EXEC0,
    EXEC1
  } state_t;

  localparam logic [2:0] OP_TCF  = 3'b001;
  localparam logic [2:0] OP_CA   = 3'b011;
  localparam logic [2:0] OP_CS   = 3'b100;
  localparam logic [2:0] OP_TS   = 3'b101;
  localparam logic [2:0] OP_AD   = 3'b110;
  localparam logic [2:0] OP_MASK = 3'b111;

  state_t        state;
  logic [AW-1:0] s_reg;
  logic [WW-1:0] g_reg;
  logic [WW-1:0] a_reg;

  logic [2:0]    opcode;
  logic [AW-1:0] dir;
  logic [WW-1:0] m_word;
  logic [WW:0]   ad_sum;
  logic [WW-1:0] ad_result;
  logic          is_load_op;
  logic          unused_rdata_msb;

  assign opcode           = g_reg[WW-1:WW-3];
  assign dir              = g_reg[AW-1:0];
  assign m_word           = mem_rdata[WW-1:0];
  assign unused_rdata_msb = mem_rdata[WW];
  assign is_load_op       = (opcode == OP_CA) || (opcode == OP_CS) ||
                            (opcode == OP_AD) || (opcode == OP_MASK);

  // One's-complement add: the carry out of the top bit wraps back into bit 0,
  // and an all-ones result (negative zero) is left as is.
  assign ad_sum    = {1'b0, a_reg} + {1'b0, m_word};
  assign ad_result = ad_sum[WW-1:0] + {{(WW-1){1'b0}}, ad_sum[WW]};

  // Bus drive; strobes are masked by reset so an aborted instruction never touches memory.
  always_comb begin
    mem_addr = s_reg;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    unique case (state)
      FETCH: mem_rd = 1'b1;
      EXEC0: begin
        if (is_load_op) begin
          mem_addr = dir;
          mem_rd   = 1'b1;
        end else if (opcode == OP_TS) begin
          mem_addr = dir;
          mem_wr   = 1'b1;
        end
      end
      EXEC1:   mem_addr = dir;
      default: ;
    endcase
    mem_rd = mem_rd & ~rst;
    mem_wr = mem_wr & ~rst;
  end

  assign mem_wdata = {1'b0, a_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT;
      s_reg     <= BOOT_ADDR;
      g_reg     <= G_INIT;
      a_reg     <= '0;
      busy      <= 1'b0;
      inst_done <= 1'b0;
    end else begin
      inst_done <= 1'b0;
      case (state)
        WAIT: begin
          if (step) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          g_reg <= m_word;
          s_reg <= s_reg + 1'b1;
          state <= EXEC0;
        end
        EXEC0: begin
          if (is_load_op) begin
            state <= EXEC1;
          end else begin
            if (opcode == OP_TCF) s_reg <= dir;
            state     <= WAIT;
            busy      <= 1'b0;
            inst_done <= 1'b1;
          end
        end
        EXEC1: begin
          case (opcode)
            OP_CA:   a_reg <= m_word;
            OP_CS:   a_reg <= ~m_word;
            OP_AD:   a_reg <= ad_result;
            OP_MASK: a_reg <= a_reg & m_word;
            default: ;
          endcase
          state     <= WAIT;
          busy      <= 1'b0;
          inst_done <= 1'b1;
        end
        default: begin
          state <= WAIT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign g_out = g_reg;
  assign a_out = a_reg;
  assign s_out = s_reg;

endmodule

// File: tb/tb_acc_core.sv
// Self-checking bench for acc_core: directed program plus random programs,
// compared against an instruction-level reference model.
module tb_acc_core;
  localparam int AW = 12;
  localparam int WW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          step = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [WW:0]   mem_wdata;
  logic [WW:0]   mem_rdata = '0;
  logic [WW-1:0] g_out;
  logic [WW-1:0] a_out;
  logic [AW-1:0] s_out;
  logic          busy;
  logic          inst_done;

  int compared = 0;
  int mismatched = 0;

  logic [WW:0]   mem    [0:4095];
  logic [WW:0]   refMem [0:4095];
  logic          fillEn = 1'b0;
  logic [31:0]   fillSeed = '0;
  logic          loadEn = 1'b0;
  logic [AW-1:0] loadAddr = '0;
  logic [WW:0]   loadData = '0;

  logic [WW-1:0] mA;
  logic [WW-1:0] mG;
  logic [AW-1:0] mS;

  acc_core dut (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .g_out     (g_out),
    .a_out     (a_out),
    .s_out     (s_out),
    .busy      (busy),
    .inst_done (inst_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fillWord(input int i, input logic [31:0] seed);
    logic [31:0] h;
    h = (i * 32'h9E3779B1) ^ seed;
    h = h ^ (h >> 13);
    h = h * 32'h85EBCA6B;
    h = h ^ (h >> 16);
    return h[15:0];
  endfunction

  // Synchronous memory: read data appears the cycle after mem_rd.
  always @(posedge clk) begin
    if (fillEn) begin
      for (int i = 0; i < 4096; i++) mem[i] <= fillWord(i, fillSeed);
    end else begin
      if (loadEn) mem[loadAddr] <= loadData;
      if (mem_wr) mem[mem_addr] <= mem_wdata;
    end
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fillMem(input logic [31:0] seed);
    for (int i = 0; i < 4096; i++) refMem[i] = fillWord(i, seed);
    fillSeed = seed;
    fillEn = 1'b1;
    @(posedge clk); #1;
    fillEn = 1'b0;
  endtask

  task automatic setMem(input logic [AW-1:0] a, input logic [WW:0] d);
    refMem[a] = d;
    loadAddr = a;
    loadData = d;
    loadEn = 1'b1;
    @(posedge clk); #1;
    loadEn = 1'b0;
  endtask

  // Reset is held together with step so the step must be ignored.
  task automatic doReset();
    rst = 1'b1;
    step = 1'b1;
    #1;
    checkOutput("rst_no_access", {mem_rd, mem_wr}, 2'b00);
    @(posedge clk); #1;
    step = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mA = '0;
    mG = 15'h2A00;
    mS = 12'h800;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", inst_done, 1'b0);
  endtask

  // Runs one instruction on the DUT and the reference model, then compares.
  task automatic applyStimulus(input bit holdStep);
    logic [15:0]   w;
    logic [2:0]    op;
    logic [AW-1:0] dir;
    logic [WW-1:0] m;
    logic [AW-1:0] expSinc;
    int            expCyc;
    bit            expWr;
    logic [AW-1:0] expWrAddr;
    logic [WW:0]   expWrData;
    int            t;
    int            n;
    int            wrCnt;
    logic [AW-1:0] gotWrAddr;
    logic [WW:0]   gotWrData;

    w = refMem[mS];
    mG = w[14:0];
    op = w[14:12];
    dir = w[11:0];
    m = refMem[dir][14:0];
    mS = mS + 1'b1;
    expSinc = mS;
    expCyc = 3;
    expWr = 0;
    expWrAddr = '0;
    expWrData = '0;
    case (op)
      3'd1: mS = dir;
      3'd3: begin mA = m; expCyc = 4; end
      3'd4: begin mA = ~m; expCyc = 4; end
      3'd6: begin
        t = int'(mA) + int'(m);
        if (t >= 32768) t = t - 32767;
        mA = t[14:0];
        expCyc = 4;
      end
      3'd7: begin mA = mA & m; expCyc = 4; end
      3'd5: begin
        expWr = 1;
        expWrAddr = dir;
        expWrData = {1'b0, mA};
        refMem[dir] = expWrData;
      end
      default: ;
    endcase

    step = 1'b1;
    @(posedge clk); #1;
    if (!holdStep) step = 1'b0;
    n = 0;
    wrCnt = 0;
    gotWrAddr = '0;
    gotWrData = '0;
    while (busy && n < 10) begin
      if (mem_wr) begin
        wrCnt++;
        gotWrAddr = mem_addr;
        gotWrData = mem_wdata;
      end
      if (n == 2) begin
        checkOutput("g_after_decode", g_out, mG);
        checkOutput("s_after_decode", s_out, expSinc);
      end
      @(posedge clk); #1;
      n++;
    end
    step = 1'b0;
    checkOutput("cycles", n, expCyc);
    checkOutput("inst_done", inst_done, 1'b1);
    checkOutput("a_reg", a_out, mA);
    checkOutput("s_reg", s_out, mS);
    checkOutput("g_reg", g_out, mG);
    checkOutput("wr_count", wrCnt, expWr ? 1 : 0);
    if (expWr) begin
      checkOutput("wr_addr", gotWrAddr, expWrAddr);
      checkOutput("wr_data", gotWrData, expWrData);
    end
    @(posedge clk); #1;
    checkOutput("idle_after", {busy, inst_done}, 2'b00);
  endtask

  initial begin
    logic [AW-1:0] sBefore;

    doReset();
    fillMem($urandom);
    for (int i = 0; i < 10; i++) begin
      checkOutput("idle_access", {busy, mem_rd, mem_wr}, 3'b000);
      @(posedge clk); #1;
    end
    checkOutput("idle_s", s_out, 12'h800);
    checkOutput("idle_g", g_out, 15'h2A00);
    checkOutput("idle_a", a_out, 15'h0000);

    setMem(12'h800, 16'h3900);
    setMem(12'h900, 16'h1234);
    setMem(12'h801, 16'h2123);
    setMem(12'h802, 16'h0456);
    setMem(12'h803, 16'h3901);
    setMem(12'h901, 16'h7FFE);
    setMem(12'h804, 16'h6902);
    setMem(12'h902, 16'h0003);
    setMem(12'h805, 16'h3903);
    setMem(12'h903, 16'h7FFF);
    setMem(12'h806, 16'h6904);
    setMem(12'h904, 16'h0000);
    setMem(12'h807, 16'h3905);
    setMem(12'h905, 16'h1ABC);
    setMem(12'h808, 16'h50A5);
    setMem(12'h809, 16'h1FFF);
    setMem(12'hFFF, 16'h1800);

    applyStimulus(0);
    checkOutput("ca_result", a_out, 15'h1234);
    applyStimulus(1);
    checkOutput("nop010_s", s_out, 12'h802);
    applyStimulus(0);
    applyStimulus(0);
    applyStimulus(0);
    checkOutput("ad_end_around", a_out, 15'h0002);
    applyStimulus(0);
    applyStimulus(0);
    checkOutput("ad_plus_zero", a_out, 15'h7FFF);
    applyStimulus(0);
    applyStimulus(0);
    checkOutput("ts_mem", mem[12'h0A5], 16'h1ABC);
    applyStimulus(0);
    checkOutput("tcf_to_fff", s_out, 12'hFFF);
    applyStimulus(0);
    checkOutput("tcf_back", s_out, 12'h800);

    // Reset landing on the EXEC0 cycle of a store must suppress the write.
    setMem(12'h800, 16'h50A6);
    setMem(12'h0A6, 16'h0777);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("ts_exec0_wr", mem_wr, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("abort_wr", mem_wr, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    mA = '0;
    mG = 15'h2A00;
    mS = 12'h800;
    checkOutput("abort_a", a_out, 15'h0000);
    checkOutput("abort_s", s_out, 12'h800);
    checkOutput("abort_g", g_out, 15'h2A00);
    checkOutput("abort_busy", busy, 1'b0);
    @(posedge clk); #1;
    checkOutput("abort_no_done", inst_done, 1'b0);
    checkOutput("abort_mem", mem[12'h0A6], 16'h0777);

    setMem(12'h800, 16'h4906);
    setMem(12'h906, 16'h0F0F);
    setMem(12'h801, 16'h3907);
    setMem(12'h907, 16'h1234);
    setMem(12'h802, 16'h7908);
    setMem(12'h908, 16'h00FF);
    applyStimulus(0);
    checkOutput("cs_result", a_out, 15'h70F0);
    applyStimulus(0);
    applyStimulus(0);
    checkOutput("mask_result", a_out, 15'h0034);

    // Random programs over pseudo-random memory images.
    for (int r = 0; r < 3; r++) begin
      fillMem($urandom);
      doReset();
      for (int k = 0; k < 80; k++) begin
        sBefore = mS;
        applyStimulus(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        if (($urandom_range(0, 15) == 0) && (sBefore != 12'hFFF)) doReset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
